// File: rtl/gba_i2s_tx.sv
// Philips I2S transmitter for the GBA stereo mix: one-entry holding buffer,
// BCLK divider, MSB-first slots with a one-bit delay, and a saturating underflow counter.
module gba_i2s_tx #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_BITS    = 32,
    parameter int BCLK_DIV     = 4,
    parameter int UF_WIDTH     = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] sample_l,
    input  logic [SAMPLE_WIDTH-1:0] sample_r,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    output logic                    i2s_bclk,
    output logic                    i2s_lrck,
    output logic                    i2s_sdata,
    output logic                    frame_start,
    output logic [UF_WIDTH-1:0]     underflow_count
);
    localparam int FRAME = 2 * SLOT_BITS;
    localparam int BW    = $clog2(FRAME);
    localparam int DW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);

    logic [DW-1:0]           div_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [SAMPLE_WIDTH-1:0] hold_l, hold_r, act_l, act_r;
    logic                    hold_full;

    logic                    div_tc, fall_tick, boundary, accept;
    logic [BW-1:0]           bit_nxt, slot_pos;
    logic                    in_right, sdata_nxt;
    logic [SAMPLE_WIDTH-1:0] hold_l_n, hold_r_n, act_l_n, act_r_n, chan, chan_sh;
    logic                    hold_full_n;
    logic [UF_WIDTH-1:0]     uf_n;

    assign div_tc    = (div_cnt == DW'(BCLK_DIV - 1));
    assign fall_tick = enable && div_tc && i2s_bclk;
    assign bit_nxt   = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
    assign boundary  = fall_tick && (bit_cnt == LAST_BIT);
    assign accept    = sample_valid && sample_ready;

    always_comb begin
        hold_l_n    = hold_l;
        hold_r_n    = hold_r;
        act_l_n     = act_l;
        act_r_n     = act_r;
        hold_full_n = hold_full;
        uf_n        = underflow_count;
        if (accept) begin
            hold_l_n    = sample_l;
            hold_r_n    = sample_r;
            hold_full_n = 1'b1;
        end
        if (boundary) begin
            if (hold_full) begin
                act_l_n     = hold_l;
                act_r_n     = hold_r;
                hold_full_n = 1'b0;
            end else if (accept) begin
                // Pair arriving on the boundary goes straight to the shifter.
                act_l_n     = sample_l;
                act_r_n     = sample_r;
                hold_full_n = 1'b0;
            end else if (underflow_count != '1) begin
                uf_n = underflow_count + UF_WIDTH'(1);
            end
        end
    end

    // Serial bit for the position being entered; uses next-frame data on the boundary.
    always_comb begin
        in_right  = (bit_nxt >= BW'(SLOT_BITS));
        slot_pos  = in_right ? bit_nxt - BW'(SLOT_BITS) : bit_nxt;
        chan      = in_right ? act_r_n : act_l_n;
        chan_sh   = chan << (slot_pos - BW'(1));
        sdata_nxt = 1'b0;
        if (slot_pos != '0 && slot_pos <= BW'(SAMPLE_WIDTH))
            sdata_nxt = chan_sh[SAMPLE_WIDTH-1];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt         <= '0;
            bit_cnt         <= LAST_BIT;
            i2s_bclk        <= 1'b0;
            i2s_lrck        <= 1'b0;
            i2s_sdata       <= 1'b0;
            frame_start     <= 1'b0;
            underflow_count <= '0;
            sample_ready    <= 1'b1;
            hold_full       <= 1'b0;
            hold_l          <= '0;
            hold_r          <= '0;
            act_l           <= '0;
            act_r           <= '0;
        end else begin
            hold_l          <= hold_l_n;
            hold_r          <= hold_r_n;
            act_l           <= act_l_n;
            act_r           <= act_r_n;
            hold_full       <= hold_full_n;
            sample_ready    <= ~hold_full_n;
            underflow_count <= uf_n;
            frame_start     <= boundary;
            if (!enable) begin
                div_cnt   <= '0;
                bit_cnt   <= LAST_BIT;
                i2s_bclk  <= 1'b0;
                i2s_lrck  <= 1'b0;
                i2s_sdata <= 1'b0;
            end else begin
                div_cnt <= div_tc ? '0 : div_cnt + DW'(1);
                if (div_tc)
                    i2s_bclk <= ~i2s_bclk;
                if (fall_tick) begin
                    bit_cnt   <= bit_nxt;
                    i2s_lrck  <= in_right;
                    i2s_sdata <= sdata_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_gba_i2s_tx.sv
// Scoreboard bench for gba_i2s_tx: stimulus queues expected frames, a monitor
// captures each complete frame on bclk rises and compares data, lrck, period and underflow.
module tb_gba_i2s_tx;
    localparam int SW = 24;
    localparam int SB = 32;
    localparam int DIV = 2;
    localparam int UW = 2;

    logic          clock = 1'b0;
    logic          reset, enable, sample_valid;
    logic [SW-1:0] sample_l, sample_r;
    logic          sample_ready, i2s_bclk, i2s_lrck, i2s_sdata, frame_start;
    logic [UW-1:0] underflow_count;

    gba_i2s_tx #(.SAMPLE_WIDTH(SW), .SLOT_BITS(SB), .BCLK_DIV(DIV), .UF_WIDTH(UW)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck),
        .i2s_sdata(i2s_sdata), .frame_start(frame_start), .underflow_count(underflow_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        logic [UW-1:0] uf;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input logic [UW-1:0] uf);
        exp_t e;
        e.l = l; e.r = r; e.uf = uf;
        q.push_back(e);
    endtask

    task automatic wait_fs(output int lat);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!frame_start && lat < 600);
        if (!frame_start) begin
            n_cmp++; n_mis++;
            $display("FAIL wait_frame_start: no pulse within %0d cycles", lat);
        end
    endtask

    task automatic push(input logic [SW-1:0] l, input logic [SW-1:0] r, output logic fs_seen);
        int w = 0;
        @(negedge clock);
        sample_valid = 1'b1; sample_l = l; sample_r = r;
        while (!sample_ready && w < 600) begin
            @(negedge clock);
            w++;
        end
        if (!sample_ready) begin
            n_cmp++; n_mis++;
            $display("FAIL push_timeout: sample_ready stuck low for %0d cycles", w);
        end
        fs_seen = frame_start;
        @(posedge clock);
    endtask

    // Monitor: capture one frame starting at frame_start, compare after 64 bclk rises.
    initial begin
        int          cap = -1;
        int          last = 0;
        logic [63:0] dbits = '0, lbits = '0;
        logic        badp = 1'b0, pb = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clock);
            if (reset || !enable) begin
                cap = -1;
            end else begin
                if (frame_start) begin
                    cap = 0; dbits = '0; lbits = '0; badp = 1'b0;
                end
                if (cap >= 0 && i2s_bclk && !pb) begin
                    if (cap > 0 && (cyc - last) != 2 * DIV) badp = 1'b1;
                    last  = cyc;
                    dbits = {dbits[62:0], i2s_sdata};
                    lbits = {lbits[62:0], i2s_lrck};
                    cap++;
                    if (cap == 2 * SB) begin
                        cap = -1;
                        if (q.size() == 0) begin
                            n_cmp++; n_mis++;
                            $display("FAIL frame_unexpected: got data %h with empty scoreboard", dbits);
                        end else begin
                            e = q.pop_front();
                            check("frame_sdata", dbits, {1'b0, e.l, 7'b0, 1'b0, e.r, 7'b0});
                            check("frame_lrck", lbits, 64'h00000000_FFFFFFFF);
                            check("bclk_period", 64'(badp), 64'(0));
                            check("frame_underflow", 64'(underflow_count), 64'(e.uf));
                        end
                    end
                end
            end
            pb = i2s_bclk;
        end
    end

    localparam logic [SW-1:0] AL = 24'hA5A5A5, AR = 24'h123456;
    localparam logic [SW-1:0] BL = 24'h800001, BR = 24'h7FFFFE;
    localparam logic [SW-1:0] CL = 24'h0F0F0F, CR = 24'hF0F0F0;
    localparam logic [SW-1:0] DL = 24'hC0FFEE, DR = 24'h000001;
    localparam logic [SW-1:0] EL = 24'hFFFFFF, ER = 24'h5A5A5A;
    localparam logic [SW-1:0] FL = 24'h111111, FR = 24'h222222;

    initial begin
        int   lat;
        logic fs;
        reset = 1'b1; enable = 1'b1; sample_valid = 1'b0; sample_l = '0; sample_r = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("rst_outputs", {60'(0), i2s_bclk, i2s_lrck, i2s_sdata, frame_start}, 64'(0));
            check("rst_ready_uf", {62'(0), sample_ready, 1'(underflow_count != 0)}, 64'(2));
        end
        enable = 1'b0; reset = 1'b0;

        // Basic frame, then a starved repeat.
        push(AL, AR, fs);
        @(negedge clock);
        sample_valid = 1'b0;
        check("ready_after_accept", 64'(sample_ready), 64'(0));
        expect_frame(AL, AR, 2'd0);
        expect_frame(AL, AR, 2'd1);
        enable = 1'b1;
        wait_fs(lat);
        check("enable_to_frame_start", 64'(lat), 64'(4));
        wait_fs(lat);

        // Back-pressure: B goes to hold, C waits until the next boundary.
        expect_frame(BL, BR, 2'd1);
        expect_frame(CL, CR, 2'd1);
        expect_frame(DL, DR, 2'd1);
        push(BL, BR, fs);
        push(CL, CR, fs);
        check("backpressure_release_at_boundary", 64'(fs), 64'(1));
        @(negedge clock);
        sample_valid = 1'b0;
        wait_fs(lat);

        // Bypass: D presented exactly in the boundary cycle of the next frame.
        repeat (255) @(negedge clock);
        sample_valid = 1'b1; sample_l = DL; sample_r = DR;
        @(negedge clock);
        check("bypass_frame_start", 64'(frame_start), 64'(1));
        check("bypass_ready", 64'(sample_ready), 64'(1));
        sample_valid = 1'b0;

        // Starved frames drive the counter into saturation.
        expect_frame(DL, DR, 2'd2);
        expect_frame(DL, DR, 2'd3);
        expect_frame(DL, DR, 2'd3);
        expect_frame(DL, DR, 2'd3);
        repeat (5) wait_fs(lat);

        // Mid-frame disable with E pending in hold.
        push(EL, ER, fs);
        @(negedge clock);
        sample_valid = 1'b0;
        repeat (40) @(negedge clock);
        check("midframe_bclk_high", 64'(i2s_bclk), 64'(1));
        check("midframe_sdata_bit10", 64'(i2s_sdata), 64'(DL[14]));
        enable = 1'b0;
        @(negedge clock);
        check("disable_outputs", {61'(0), i2s_bclk, i2s_lrck, i2s_sdata}, 64'(0));
        check("disable_keeps_hold", 64'(sample_ready), 64'(0));
        check("disable_keeps_uf", 64'(underflow_count), 64'(3));
        expect_frame(EL, ER, 2'd3);
        repeat (3) @(negedge clock);
        enable = 1'b1;
        wait_fs(lat);
        check("reenable_to_frame_start", 64'(lat), 64'(4));
        wait_fs(lat);

        // Mid-frame reset with F pending: F is lost, active returns to zero.
        push(FL, FR, fs);
        @(negedge clock);
        sample_valid = 1'b0;
        repeat (40) @(negedge clock);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {61'(0), i2s_bclk, i2s_lrck, i2s_sdata}, 64'(0));
        repeat (3) @(negedge clock);
        check("reset_drops_hold", 64'(sample_ready), 64'(1));
        check("reset_clears_uf", 64'(underflow_count), 64'(0));
        expect_frame('0, '0, 2'd1);
        reset = 1'b0;
        wait_fs(lat);
        check("post_reset_to_frame_start", 64'(lat), 64'(4));
        wait_fs(lat);
        enable = 1'b0;
        repeat (4) @(negedge clock);
        check("scoreboard_drained", 64'(q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
